// File: rtl/led_sequencer.sv
// LED colour sequencer.
// Cycles a 2-bit colour code (red, green, blue, yellow) for an external LED
// decoder. In auto mode each code is held for TICK_DIV*max(dwell,1) clock
// cycles. In manual mode the code advances on each step pulse. Sequencing
// can be paused and resumed. A second stop while paused returns to idle.
// All outputs come straight from flops.
module led_sequencer #(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       mode,
  input  logic [7:0] dwell,
  output logic [1:0] dataOut,
  output logic       ledOn,
  output logic       busy,
  output logic       wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t          state_q;
  logic [1:0]      code_q;
  logic            ledOn_q;
  logic            busy_q;
  logic            wrap_q;
  logic [PW-1:0]   presc_q;
  logic [7:0]      dwellCnt_q;
  logic [7:0]      dwellLat_q;
  logic            mode_q;

  logic [7:0]      dwellEff;
  logic            tick;
  logic            expire;
  logic            modeChange;

  // Timer decode: a dwell of zero behaves as one tick; expiry is the last tick of a colour
  always_comb begin
    dwellEff   = (dwellLat_q == 8'd0) ? 8'd1 : dwellLat_q;
    tick       = (presc_q == PRESC_LAST);
    expire     = tick && (dwellCnt_q == (dwellEff - 8'd1));
    modeChange = (mode != mode_q);
  end

  // Sequencer FSM with registered outputs; stop always beats start and any advance
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      code_q     <= 2'd0;
      ledOn_q    <= 1'b0;
      busy_q     <= 1'b0;
      wrap_q     <= 1'b0;
      presc_q    <= '0;
      dwellCnt_q <= 8'd0;
      dwellLat_q <= 8'd0;
      mode_q     <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      mode_q <= mode;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q    <= RUN;
            code_q     <= 2'd0;
            presc_q    <= '0;
            dwellCnt_q <= 8'd0;
            dwellLat_q <= dwell;
            ledOn_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= PAUSE;
            ledOn_q <= 1'b0;
          end else if (modeChange) begin
            presc_q    <= '0;
            dwellCnt_q <= 8'd0;
          end else if (!mode) begin
            if (tick) begin
              presc_q <= '0;
              if (expire) begin
                code_q     <= code_q + 2'd1;
                wrap_q     <= (code_q == 2'd3);
                dwellCnt_q <= 8'd0;
                dwellLat_q <= dwell;
              end else begin
                dwellCnt_q <= dwellCnt_q + 8'd1;
              end
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end else begin
            presc_q    <= '0;
            dwellCnt_q <= 8'd0;
            if (step) begin
              code_q <= code_q + 2'd1;
              wrap_q <= (code_q == 2'd3);
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            state_q <= IDLE;
            code_q  <= 2'd0;
            ledOn_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (start) begin
            state_q    <= RUN;
            presc_q    <= '0;
            dwellCnt_q <= 8'd0;
            dwellLat_q <= dwell;
            ledOn_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          code_q  <= 2'd0;
          ledOn_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dataOut = code_q;
  assign ledOn   = ledOn_q;
  assign busy    = busy_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (TICK_DIV = 4).
// A table of single-cycle vectors, hand-written multi-cycle sequences and a
// randomized run compared against a cycle-count reference model.
module tb_led_sequencer;

  localparam int TD = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       step;
  logic       mode;
  logic [7:0] dwell;
  logic [1:0] dataOut;
  logic       ledOn;
  logic       busy;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  led_sequencer #(.TICK_DIV(TD)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .step    (step),
    .mode    (mode),
    .dwell   (dwell),
    .dataOut (dataOut),
    .ledOn   (ledOn),
    .busy    (busy),
    .wrap    (wrap)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 running, 2 paused. Auto-mode timing is kept as
  // cycles spent in the current colour against the colour's total hold length.
  int mState   = 0;
  int mCode    = 0;
  bit mWrap    = 1'b0;
  int mElapsed = 0;
  int mHold    = TD;
  bit mPrevMode = 1'b0;

  function automatic int holdFor(input logic [7:0] d);
    return TD * ((d == 8'd0) ? 1 : int'(d));
  endfunction

  task automatic modelAdvance();
    if (mCode == 3) mWrap = 1'b1;
    mCode = (mCode + 1) % 4;
  endtask

  task automatic modelUpdate();
    mWrap = 1'b0;
    if (rst) begin
      mState    = 0;
      mCode     = 0;
      mElapsed  = 0;
      mHold     = TD;
      mPrevMode = 1'b0;
    end else begin
      case (mState)
        0: begin
          if (start && !stop) begin
            mState   = 1;
            mCode    = 0;
            mElapsed = 0;
            mHold    = holdFor(dwell);
          end
        end
        1: begin
          if (stop) begin
            mState = 2;
          end else if (mode != mPrevMode) begin
            mElapsed = 0;
          end else if (!mode) begin
            if (mElapsed + 1 == mHold) begin
              modelAdvance();
              mElapsed = 0;
              mHold    = holdFor(dwell);
            end else begin
              mElapsed++;
            end
          end else begin
            mElapsed = 0;
            if (step) modelAdvance();
          end
        end
        default: begin
          if (stop) begin
            mState = 0;
            mCode  = 0;
          end else if (start) begin
            mState   = 1;
            mElapsed = 0;
            mHold    = holdFor(dwell);
          end
        end
      endcase
      mPrevMode = mode;
    end
  endtask

  // Drive inputs, clock one edge, update the model, then settle on the falling edge
  task automatic applyStimulus(input logic r, input logic sa, input logic so,
                               input logic se, input logic m, input logic [7:0] d);
    rst   = r;
    start = sa;
    stop  = so;
    step  = se;
    mode  = m;
    dwell = d;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [1:0] expCode,
                             input logic expLed, input logic expBusy, input logic expWrap);
    checks++;
    if ({dataOut, ledOn, busy, wrap} !== {expCode, expLed, expBusy, expWrap}) begin
      errors++;
      $display("[TB] FAIL %s: got dataOut=%0d ledOn=%0b busy=%0b wrap=%0b, expected dataOut=%0d ledOn=%0b busy=%0b wrap=%0b",
               name, dataOut, ledOn, busy, wrap, expCode, expLed, expBusy, expWrap);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, 2'(mCode), (mState == 1), (mState != 0), mWrap);
  endtask

  typedef struct {
    logic       r;
    logic       sa;
    logic       so;
    logic       se;
    logic       m;
    logic [7:0] d;
    logic [1:0] code;
    logic       led;
    logic       bsy;
    logic       wr;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic sa, input logic so, input logic se,
                        input logic m, input logic [7:0] d, input logic [1:0] code,
                        input logic led, input logic bsy, input logic wr, input string name);
    vec_t v;
    v.r = r; v.sa = sa; v.so = so; v.se = se; v.m = m; v.d = d;
    v.code = code; v.led = led; v.bsy = bsy; v.wr = wr; v.name = name;
    vecs.push_back(v);
  endtask

  // Main test sequence: table vectors, directed sequences, then random
  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; mode = 1'b0; dwell = 8'd0;
    @(negedge clk);

    //      rst sta sto stp mod dwell  code led bsy wrp name
    addVec(1, 0, 0, 0, 0, 8'd1, 2'd0, 0, 0, 0, "resetState");
    addVec(0, 1, 0, 0, 1, 8'd1, 2'd0, 1, 1, 0, "startManual");
    addVec(0, 0, 0, 1, 1, 8'd1, 2'd1, 1, 1, 0, "step1");
    addVec(0, 0, 0, 0, 1, 8'd1, 2'd1, 1, 1, 0, "manualHold");
    addVec(0, 0, 0, 1, 1, 8'd1, 2'd2, 1, 1, 0, "step2");
    addVec(0, 0, 0, 1, 1, 8'd1, 2'd3, 1, 1, 0, "step3");
    addVec(0, 0, 0, 1, 1, 8'd1, 2'd0, 1, 1, 1, "manualWrap");
    addVec(0, 0, 0, 0, 1, 8'd1, 2'd0, 1, 1, 0, "wrapOneCycle");
    addVec(0, 0, 0, 1, 0, 8'd1, 2'd0, 1, 1, 0, "modeChangeNoAdvance");
    addVec(0, 0, 0, 1, 0, 8'd1, 2'd0, 1, 1, 0, "stepIgnoredAuto");
    addVec(0, 0, 0, 0, 0, 8'd1, 2'd0, 1, 1, 0, "autoCount2");
    addVec(0, 0, 0, 0, 0, 8'd1, 2'd0, 1, 1, 0, "autoCount3");
    addVec(0, 0, 0, 0, 0, 8'd1, 2'd1, 1, 1, 0, "autoExpire");
    addVec(0, 1, 1, 0, 0, 8'd1, 2'd1, 0, 1, 0, "runStopWins");
    addVec(0, 0, 0, 1, 0, 8'd1, 2'd1, 0, 1, 0, "stepIgnoredPause");
    addVec(0, 1, 1, 0, 0, 8'd1, 2'd0, 0, 0, 0, "pauseStopWins");
    addVec(0, 1, 1, 0, 0, 8'd1, 2'd0, 0, 0, 0, "idleStartStop");
    addVec(0, 0, 0, 1, 1, 8'd1, 2'd0, 0, 0, 0, "stepIgnoredIdle");
    addVec(0, 1, 0, 0, 0, 8'd1, 2'd0, 1, 1, 0, "restart");
    addVec(1, 1, 0, 1, 1, 8'd1, 2'd0, 0, 0, 0, "resetBeatsStart");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].sa, vecs[i].so, vecs[i].se, vecs[i].m, vecs[i].d);
      checkOutput(vecs[i].name, vecs[i].code, vecs[i].led, vecs[i].bsy, vecs[i].wr);
    end

    // Auto run with dwell 2: each code held 8 cycles, wrap at 3 -> 0
    applyStimulus(1, 0, 0, 0, 0, 8'd2);
    checkOutput("seqReset", 2'd0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 8'd2);
    checkOutput("seqStart", 2'd0, 1, 1, 0);
    for (int k = 1; k <= 50; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 8'd2);
      checkOutput("autoDwell2", 2'((k / 8) % 4), 1, 1, (k == 32));
    end

    // Pause at code 2, resume with a full hold, then stop twice to idle
    applyStimulus(0, 0, 1, 0, 0, 8'd2);
    checkOutput("pauseAt2", 2'd2, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 8'd2);
    checkOutput("resumeAt2", 2'd2, 1, 1, 0);
    for (int j = 1; j <= 8; j++) begin
      applyStimulus(0, 0, 0, 0, 0, 8'd2);
      checkOutput("resumeFullHold", (j < 8) ? 2'd2 : 2'd3, 1, 1, 0);
    end
    applyStimulus(0, 0, 1, 0, 0, 8'd2);
    checkOutput("stopOnce", 2'd3, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0, 8'd2);
    checkOutput("stopTwiceIdle", 2'd0, 0, 0, 0);

    // Dwell 0 behaves as 1: advance every 4 cycles; stop on expiry wins
    applyStimulus(0, 1, 0, 0, 0, 8'd0);
    checkOutput("startDwell0", 2'd0, 1, 1, 0);
    for (int j = 1; j <= 15; j++) begin
      applyStimulus(0, 0, 0, 0, 0, 8'd0);
      checkOutput("autoDwell0", 2'((j / 4) % 4), 1, 1, 0);
    end
    applyStimulus(0, 0, 1, 0, 0, 8'd0);
    checkOutput("stopAtExpiry", 2'd3, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 8'd0);
    checkOutput("resumeAt3", 2'd3, 1, 1, 0);
    applyStimulus(1, 1, 0, 1, 1, 8'd0);
    checkOutput("resetMidRun", 2'd0, 0, 0, 0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      logic r, sa, so, se, m;
      r  = ($urandom % 64) == 0;
      sa = ($urandom % 8) == 0;
      so = ($urandom % 16) == 0;
      se = ($urandom % 3) == 0;
      m  = (($urandom % 32) == 0) ? ~mode : mode;
      applyStimulus(r, sa, so, se, m, 8'($urandom_range(0, 3)));
      checkModel("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
